// File: rtl/instruction_fetch_unit_pkg.sv
// fetch_pkg: shared types and constants for the instruction fetch stage.
//   fetch_state_t    - fetch FSM states (IDLE, REQ, WAIT, HOLD, FLUSH)
//   WORD_BYTES       - PC increment per instruction word
//   DEFAULT_RESET_PC - default PC loaded at reset
//   word_align()     - forces a byte address onto a word boundary
package fetch_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        HOLD,
        FLUSH
    } fetch_state_t;

    localparam int unsigned WORD_BYTES       = 4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: fetch stage feeding the decoder.
// Holds the PC, issues one word request at a time to instruction memory and
// presents each returned word with its PC over a valid/ready handshake.
// Redirects from execute flush any in-flight fetch and restart at the target.
// Ports:
//   clk            - clock, rising edge
//   reset          - asynchronous, active-low reset
//   imem_req       - one-cycle request strobe to instruction memory
//   imem_addr      - byte address of the requested word
//   imem_rvalid    - memory response strobe
//   imem_rdata     - memory response word
//   redirect_valid - one-cycle redirect strobe from execute
//   redirect_pc    - redirect target (low two bits ignored)
//   inst_valid     - instruction/pc_out valid toward decode
//   inst_ready     - decode accepts this cycle
//   instruction    - fetched word
//   pc_out         - address of the presented instruction
//   fetch_count    - number of instructions handed to decode (wraps)
module instruction_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] instruction,
    output logic [31:0] pc_out,
    output logic [31:0] fetch_count
);

    fetch_state_t state, state_nxt;
    logic [31:0]  pc, pc_nxt;
    logic [31:0]  instr_q;
    logic [31:0]  pc_out_q;
    logic [31:0]  count_q;
    logic         capture;
    logic         accept;

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        capture   = 1'b0;
        accept    = 1'b0;
        case (state)
            IDLE: state_nxt = REQ;
            REQ: begin
                if (redirect_valid) begin
                    // Request already went out this cycle; its response must be drained.
                    pc_nxt    = word_align(redirect_pc);
                    state_nxt = FLUSH;
                end else begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (redirect_valid) begin
                    pc_nxt    = word_align(redirect_pc);
                    state_nxt = imem_rvalid ? REQ : FLUSH;
                end else if (imem_rvalid) begin
                    capture   = 1'b1;
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                // Redirect wins over a same-cycle handshake.
                if (redirect_valid) begin
                    pc_nxt    = word_align(redirect_pc);
                    state_nxt = REQ;
                end else if (inst_ready) begin
                    accept    = 1'b1;
                    pc_nxt    = pc + 32'(WORD_BYTES);
                    state_nxt = REQ;
                end
            end
            FLUSH: begin
                if (redirect_valid) begin
                    pc_nxt = word_align(redirect_pc);
                end
                if (imem_rvalid) begin
                    state_nxt = REQ;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            pc       <= RESET_PC;
            instr_q  <= '0;
            pc_out_q <= '0;
            count_q  <= '0;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            if (capture) begin
                instr_q  <= imem_rdata;
                pc_out_q <= pc;
            end
            if (accept) begin
                count_q <= count_q + 32'd1;
            end
        end
    end

    // All outputs derive from registers only.
    assign imem_req    = (state == REQ);
    assign imem_addr   = pc;
    assign inst_valid  = (state == HOLD);
    assign instruction = instr_q;
    assign pc_out      = pc_out_q;
    assign fetch_count = count_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
module tb_instruction_fetch_unit;

    logic        clk;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] instruction;
    logic [31:0] pc_out;
    logic [31:0] fetch_count;

    instruction_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk           (clk),
        .reset         (reset),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_rvalid   (imem_rvalid),
        .imem_rdata    (imem_rdata),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .inst_valid    (inst_valid),
        .inst_ready    (inst_ready),
        .instruction   (instruction),
        .pc_out        (pc_out),
        .fetch_count   (fetch_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
    } exp_t;
    exp_t        exp_q[$];
    logic [31:0] addr_q[$];

    // Memory: auto mode answers every request the next cycle with
    // {addr[15:0], ~addr[15:0]}; manual mode is driven by the stimulus.
    logic        auto_mode;
    logic        auto_rv;
    logic [31:0] auto_rd;
    logic        man_rv;
    logic [31:0] man_rd;

    always @(posedge clk) begin
        auto_rv <= imem_req;
        auto_rd <= {imem_addr[15:0], ~imem_addr[15:0]};
    end
    assign imem_rvalid = auto_mode ? auto_rv : man_rv;
    assign imem_rdata  = auto_mode ? auto_rd : man_rd;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [31:0] pc, input logic [31:0] ins);
        exp_t e;
        e.pc  = pc;
        e.ins = ins;
        exp_q.push_back(e);
    endtask

    // Monitor: checks every request address and every accepted instruction.
    always @(negedge clk) begin
        if (reset && imem_req) begin
            n_cmp++;
            if (addr_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_req: got addr %h, expected no request", imem_addr);
            end else begin
                logic [31:0] ea;
                ea = addr_q.pop_front();
                if (imem_addr !== ea) begin
                    n_err++;
                    $display("FAIL req_addr: got %h, expected %h", imem_addr, ea);
                end
            end
        end
        if (reset && inst_valid) begin
            n_cmp++;
            if (instruction === 32'hDEAD_BEEF) begin
                n_err++;
                $display("FAIL flushed_word_leak: got %h, expected anything but deadbeef", instruction);
            end
        end
        if (reset && inst_valid && inst_ready && !redirect_valid) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_accept: got pc %h ins %h, expected none", pc_out, instruction);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (pc_out !== e.pc || instruction !== e.ins) begin
                    n_err++;
                    $display("FAIL accept: got pc %h ins %h, expected pc %h ins %h",
                             pc_out, instruction, e.pc, e.ins);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_hold(input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (inst_valid) begin
                seen = 1'b1;
                break;
            end
            step();
        end
        n_cmp++;
        if (!seen) begin
            n_err++;
            $display("FAIL %s: got no inst_valid within 50 cycles, expected inst_valid=1", name);
        end
    endtask

    task automatic handshake();
        inst_ready = 1'b1;
        step();
        inst_ready = 1'b0;
    endtask

    initial begin
        reset          = 1'b0;
        auto_mode      = 1'b1;
        man_rv         = 1'b0;
        man_rd         = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        inst_ready     = 1'b0;
        #23;
        chk("rst_imem_req",    {31'd0, imem_req},   32'd0);
        chk("rst_imem_addr",   imem_addr,           32'h0000_0000);
        chk("rst_inst_valid",  {31'd0, inst_valid}, 32'd0);
        chk("rst_instruction", instruction,         32'd0);
        chk("rst_pc_out",      pc_out,              32'd0);
        chk("rst_fetch_count", fetch_count,         32'd0);

        // Sequential fetch from reset PC.
        addr_q.push_back(32'h0); addr_q.push_back(32'h4);
        addr_q.push_back(32'h8); addr_q.push_back(32'hC);
        addr_q.push_back(32'h10);
        push_exp(32'h0, 32'h0000_FFFF); push_exp(32'h4, 32'h0004_FFFB);
        push_exp(32'h8, 32'h0008_FFF7); push_exp(32'hC, 32'h000C_FFF3);
        push_exp(32'h10, 32'h0010_FFEF);
        @(posedge clk); #1;
        reset = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wait_hold("seq_hold");
            handshake();
        end
        chk("seq_fetch_count", fetch_count, 32'd4);

        // Stall in HOLD for five cycles.
        wait_hold("stall_hold");
        auto_mode = 1'b0;
        for (int k = 0; k < 5; k++) begin
            chk("stall_valid",       {31'd0, inst_valid}, 32'd1);
            chk("stall_instruction", instruction,         32'h0010_FFEF);
            chk("stall_pc_out",      pc_out,              32'h10);
            chk("stall_no_req",      {31'd0, imem_req},   32'd0);
            chk("stall_fetch_count", fetch_count,         32'd4);
            step();
        end
        addr_q.push_back(32'h14);
        handshake();                      // now REQ 0x14
        chk("stall_done_count", fetch_count, 32'd5);

        // Redirect in WAIT, response arrives three cycles later and is dropped.
        addr_q.push_back(32'h100);
        push_exp(32'h100, 32'h0100_FEFF);
        step();                           // now WAIT
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0103;
        step();                           // now FLUSH
        redirect_valid = 1'b0;
        chk("flush_no_valid", {31'd0, inst_valid}, 32'd0);
        step();
        man_rv = 1'b1;
        man_rd = 32'hDEAD_BEEF;
        step();                           // response drained, now REQ 0x100
        man_rv    = 1'b0;
        auto_mode = 1'b1;
        wait_hold("redir_wait_hold");
        handshake();
        chk("redir_wait_count", fetch_count, 32'd6);

        // Redirect on the same cycle as a handshake.
        addr_q.push_back(32'h104);
        addr_q.push_back(32'h200);
        push_exp(32'h200, 32'h0200_FDFF);
        wait_hold("redir_hs_hold");
        inst_ready     = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0200;
        step();
        inst_ready     = 1'b0;
        redirect_valid = 1'b0;
        chk("redir_hs_count", fetch_count,         32'd6);
        chk("redir_hs_valid", {31'd0, inst_valid}, 32'd0);
        wait_hold("redir_tgt_hold");
        handshake();
        chk("redir_tgt_count", fetch_count, 32'd7);

        // PC wrap from FFFF_FFFC to 0.
        addr_q.push_back(32'h204);
        addr_q.push_back(32'hFFFF_FFFC);
        addr_q.push_back(32'h0);
        push_exp(32'hFFFF_FFFC, 32'hFFFC_0003);
        push_exp(32'h0, 32'h0000_FFFF);
        wait_hold("wrap_pre_hold");
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        step();
        redirect_valid = 1'b0;
        wait_hold("wrap_hold");
        handshake();
        chk("wrap_addr", imem_addr, 32'h0000_0000);
        wait_hold("wrap_zero_hold");
        auto_mode = 1'b0;
        chk("wrap_zero_instruction", instruction, 32'h0000_FFFF);
        addr_q.push_back(32'h4);
        handshake();                      // now REQ 0x4
        chk("wrap_count", fetch_count, 32'd9);

        // Reset asserted in WAIT; stale responses during and after reset.
        step();                           // now WAIT
        reset = 1'b0;
        #1;
        chk("midrst_imem_req",    {31'd0, imem_req},   32'd0);
        chk("midrst_imem_addr",   imem_addr,           32'h0);
        chk("midrst_inst_valid",  {31'd0, inst_valid}, 32'd0);
        chk("midrst_instruction", instruction,         32'd0);
        chk("midrst_pc_out",      pc_out,              32'd0);
        chk("midrst_fetch_count", fetch_count,         32'd0);
        man_rv = 1'b1;
        man_rd = 32'hBAD0_0001;
        step();
        man_rv = 1'b0;
        step();
        reset  = 1'b1;
        man_rv = 1'b1;
        man_rd = 32'hBAD0_0002;
        addr_q.push_back(32'h0);
        push_exp(32'h0, 32'h0000_FFFF);
        step();                           // IDLE ignored the stale response
        man_rv    = 1'b0;
        auto_mode = 1'b1;
        wait_hold("postrst_hold");
        chk("postrst_instruction", instruction, 32'h0000_FFFF);
        handshake();
        chk("postrst_count", fetch_count, 32'd1);

        chk("exp_q_drained",  exp_q.size(),  32'd0);
        chk("addr_q_drained", addr_q.size() > 1 ? 32'd1 : 32'd0, 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
